// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run/stall/pipeline-reset controller.
package cpu_run_ctrl_pkg;

    localparam int RUN_STATE_W = 3;

    typedef enum logic [RUN_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_DRAIN = 3'd4
    } run_state_e;

    // States in which the pipeline is allowed to issue.
    function automatic logic is_active(input run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_shift_chain.sv
// 1-bit shift register with asynchronous reset to a chosen value; q[0] is the first stage.
module cpu_shift_chain #(
    parameter int   DEPTH = 4,
    parameter logic INIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    logic [DEPTH-1:0] q_q, q_d;

    always_comb begin
        q_d    = q_q;
        q_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            q_d[i] = q_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= {DEPTH{INIT}};
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/stall/pipeline-reset controller: host command FSM, single-step and drain counters,
// run-cycle counter and per-stage stall/flush vectors for an N-stage pipeline.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int                 NUM_STAGES  = 5,
    parameter int                 NUM_SRC     = 2,
    parameter logic [NUM_SRC-1:0] FREEZE_MASK = '1,
    parameter int                 STEP_W      = 16,
    parameter int                 CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   init_calib_complete,
    input  logic                   cpu_start,
    input  logic                   quit_cmd,
    input  logic                   step_cmd,
    input  logic [STEP_W-1:0]      step_num,
    input  logic [NUM_SRC-1:0]     stall_req,
    input  logic                   cnt_clr,
    output logic                   pc_start,
    output logic                   stall,
    output logic [NUM_STAGES-1:0]  stall_stg,
    output logic                   stall_1shot,
    output logic [NUM_STAGES-1:0]  rst_pipe,
    output logic [RUN_STATE_W-1:0] run_state,
    output logic                   step_done,
    output logic [CNT_W-1:0]       run_cnt
);

    localparam int DRN_W = $clog2(NUM_STAGES + 1);

    run_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    logic              pc_start_q, pc_start_d;

    logic                  active, stall_i, freeze, flush_req, step_done_i;
    logic [NUM_STAGES-2:0] dly;

    assign active  = is_active(state_q);
    assign stall_i = !active || (|stall_req);
    assign freeze  = |(stall_req & FREEZE_MASK);

    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        drain_cnt_d = drain_cnt_q;
        flush_req   = 1'b0;
        step_done_i = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!quit_cmd) begin
                    if (cpu_start) begin
                        if (init_calib_complete) begin
                            state_d   = ST_RUN;
                            flush_req = 1'b1;
                        end else begin
                            state_d = ST_PEND;
                        end
                    end else if (step_cmd && init_calib_complete) begin
                        state_d    = ST_STEP;
                        flush_req  = 1'b1;
                        step_cnt_d = (step_num == '0) ? STEP_W'(1) : step_num;
                    end
                end
            end
            ST_PEND: begin
                // The flush for a deferred start goes out together with pc_start.
                if (quit_cmd) begin
                    state_d = ST_IDLE;
                end else if (init_calib_complete) begin
                    state_d   = ST_RUN;
                    flush_req = 1'b1;
                end
            end
            ST_RUN: begin
                if (quit_cmd) begin
                    state_d     = ST_DRAIN;
                    flush_req   = 1'b1;
                    drain_cnt_d = DRN_W'(NUM_STAGES - 1);
                end else if (!init_calib_complete) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (quit_cmd) begin
                    state_d     = ST_DRAIN;
                    flush_req   = 1'b1;
                    drain_cnt_d = DRN_W'(NUM_STAGES - 1);
                end else if (!init_calib_complete) begin
                    state_d = ST_IDLE;
                end else if (!stall_i) begin
                    if (step_cnt_q == STEP_W'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRN_W'(NUM_STAGES - 1);
                        step_done_i = 1'b1;
                    end else begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) state_d = ST_IDLE;
                else                   drain_cnt_d = drain_cnt_q - DRN_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_start_d = is_active(state_d) && !is_active(state_q);
        run_cnt_d  = run_cnt_q;
        if (cnt_clr)                 run_cnt_d = '0;
        else if (active && !stall_i) run_cnt_d = run_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_cnt_q  <= '0;
            drain_cnt_q <= '0;
            run_cnt_q   <= '0;
            pc_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_cnt_q  <= step_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            run_cnt_q   <= run_cnt_d;
            pc_start_q  <= pc_start_d;
        end
    end

    // dly[k-1] is stall delayed by k cycles; resets high so the pipe starts fully held.
    cpu_shift_chain #(.DEPTH(NUM_STAGES - 1), .INIT(1'b1)) u_stall_dly (
        .clk (clk),
        .rst (rst),
        .din (stall_i),
        .q   (dly)
    );

    cpu_shift_chain #(.DEPTH(NUM_STAGES), .INIT(1'b0)) u_flush (
        .clk (clk),
        .rst (rst),
        .din (flush_req),
        .q   (rst_pipe)
    );

    // A drain-forward stall reaches stage i only after stall has been high for i cycles.
    always_comb begin : p_stg
        logic acc;
        acc          = stall_i;
        stall_stg    = '0;
        stall_stg[0] = stall_i;
        for (int i = 1; i < NUM_STAGES; i++) begin
            acc          = acc & dly[i-1];
            stall_stg[i] = freeze | acc;
        end
    end

    assign stall       = stall_i;
    assign stall_1shot = stall_i & ~dly[0];
    assign pc_start    = pc_start_q;
    assign run_state   = state_q;
    assign step_done   = step_done_i;
    assign run_cnt     = run_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-cycle vector table through a scoreboard queue, plus
// hand-written sequences for deferred start, zero-length step and mid-step reset.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        calib, cpu_start, quit_cmd, step_cmd, cnt_clr;
    logic [15:0] step_num;
    logic [1:0]  stall_req;

    logic        pc_start, stall, stall_1shot, step_done;
    logic [4:0]  stall_stg, rst_pipe;
    logic [2:0]  run_state;
    logic [31:0] run_cnt;

    logic        f_pc_start, f_stall, f_stall_1shot, f_step_done;
    logic [4:0]  f_stall_stg, f_rst_pipe;
    logic [2:0]  f_run_state;
    logic [31:0] f_run_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Source 0 drains forward here.
    cpu_run_ctrl #(.NUM_STAGES(5), .NUM_SRC(2), .FREEZE_MASK(2'b10), .STEP_W(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .init_calib_complete(calib), .cpu_start(cpu_start),
        .quit_cmd(quit_cmd), .step_cmd(step_cmd), .step_num(step_num), .stall_req(stall_req),
        .cnt_clr(cnt_clr), .pc_start(pc_start), .stall(stall), .stall_stg(stall_stg),
        .stall_1shot(stall_1shot), .rst_pipe(rst_pipe), .run_state(run_state),
        .step_done(step_done), .run_cnt(run_cnt)
    );

    // Source 0 freezes every stage here.
    cpu_run_ctrl #(.NUM_STAGES(5), .NUM_SRC(2), .FREEZE_MASK(2'b01), .STEP_W(16), .CNT_W(32)) dut_f (
        .clk(clk), .rst(rst), .init_calib_complete(calib), .cpu_start(cpu_start),
        .quit_cmd(quit_cmd), .step_cmd(step_cmd), .step_num(step_num), .stall_req(stall_req),
        .cnt_clr(cnt_clr), .pc_start(f_pc_start), .stall(f_stall), .stall_stg(f_stall_stg),
        .stall_1shot(f_stall_1shot), .rst_pipe(f_rst_pipe), .run_state(f_run_state),
        .step_done(f_step_done), .run_cnt(f_run_cnt)
    );

    typedef struct {
        logic        cal, st, qt, sp, clr;
        logic [1:0]  sr;
        logic [2:0]  est;
        logic        pc, stl, s1;
        logic [4:0]  stg, stgf, rp;
        logic        sd;
        logic [31:0] rc;
    } vec_t;

    vec_t vtab[$];
    vec_t sb[$];

    task automatic add(input logic cal, st, qt, sp, clr, input logic [1:0] sr,
                       input logic [2:0] est, input logic pc, stl, s1,
                       input logic [4:0] stg, stgf, rp, input logic sd, input int rc);
        vec_t v;
        v.cal = cal; v.st = st; v.qt = qt; v.sp = sp; v.clr = clr; v.sr = sr;
        v.est = est; v.pc = pc; v.stl = stl; v.s1 = s1; v.stg = stg; v.stgf = stgf;
        v.rp = rp; v.sd = sd; v.rc = rc;
        vtab.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_start = 1'b0; quit_cmd = 1'b0; step_cmd = 1'b0; cnt_clr = 1'b0; stall_req = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t e;
        rst = 1'b1; calib = 1'b0; cpu_start = 1'b0; quit_cmd = 1'b0; step_cmd = 1'b0;
        cnt_clr = 1'b0; stall_req = 2'b00; step_num = 16'd3;
        #3;
        chk("rst.state",    run_state,   3'd0);
        chk("rst.pc_start", pc_start,    1'b0);
        chk("rst.stall",    stall,       1'b1);
        chk("rst.stall_stg",stall_stg,   5'b11111);
        chk("rst.rst_pipe", rst_pipe,    5'b00000);
        chk("rst.step_done",step_done,   1'b0);
        chk("rst.run_cnt",  run_cnt,     32'd0);
        #9 rst = 1'b0;

        //  cal st qt sp clr sr     st  pc stl s1 stg       stgf      rp        sd rc
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0);  // c0
        add(1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0);  // start
        add(1, 0, 0, 0, 0, 2'b00, 2, 1, 0, 0, 5'b00000, 5'b00000, 5'b00001, 0, 0);
        add(1, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b00010, 0, 1);
        add(1, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b00100, 0, 2);
        add(1, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b01000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b10000, 0, 4);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 1, 5'b00001, 5'b11111, 5'b00000, 0, 5);  // stall 8 cycles
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b00011, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b00111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b01111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b01, 2, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 5);
        add(1, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 5);
        add(1, 1, 1, 0, 0, 2'b00, 2, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0, 6);  // quit+start
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 1, 5'b00001, 5'b00001, 5'b00001, 0, 7);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b00011, 5'b00011, 5'b00010, 0, 7);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b00111, 5'b00111, 5'b00100, 0, 7);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b01111, 5'b01111, 5'b01000, 0, 7);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b11111, 5'b11111, 5'b10000, 0, 7);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 7);
        add(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 7);  // quit in IDLE
        add(1, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 7);  // clear
        add(1, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 0);  // step 3
        add(1, 0, 0, 0, 0, 2'b00, 3, 1, 0, 0, 5'b00000, 5'b00000, 5'b00001, 0, 0);
        add(1, 0, 0, 0, 0, 2'b00, 3, 0, 0, 0, 5'b00000, 5'b00000, 5'b00010, 0, 1);
        add(1, 0, 0, 0, 0, 2'b00, 3, 0, 0, 0, 5'b00000, 5'b00000, 5'b00100, 1, 2);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 1, 5'b00001, 5'b00001, 5'b01000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b00011, 5'b00011, 5'b10000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b00111, 5'b00111, 5'b00000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b01111, 5'b01111, 5'b00000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 4, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 3);
        add(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 5'b11111, 5'b11111, 5'b00000, 0, 3);

        for (int i = 0; i < vtab.size(); i++) begin
            @(posedge clk);
            #1;
            calib = vtab[i].cal; cpu_start = vtab[i].st; quit_cmd = vtab[i].qt;
            step_cmd = vtab[i].sp; cnt_clr = vtab[i].clr; stall_req = vtab[i].sr;
            sb.push_back(vtab[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d.state", i),     run_state,   e.est);
            chk($sformatf("v%0d.pc_start", i),  pc_start,    e.pc);
            chk($sformatf("v%0d.stall", i),     stall,       e.stl);
            chk($sformatf("v%0d.stall_1shot", i), stall_1shot, e.s1);
            chk($sformatf("v%0d.stall_stg", i), stall_stg,   e.stg);
            chk($sformatf("v%0d.rst_pipe", i),  rst_pipe,    e.rp);
            chk($sformatf("v%0d.step_done", i), step_done,   e.sd);
            chk($sformatf("v%0d.run_cnt", i),   run_cnt,     e.rc);
            chk($sformatf("v%0d.frz_stall_stg", i), f_stall_stg, e.stgf);
            chk($sformatf("v%0d.frz_misc", i),
                {f_run_state, f_pc_start, f_stall, f_stall_1shot, f_rst_pipe, f_step_done},
                {e.est, e.pc, e.stl, e.s1, e.rp, e.sd});
            chk($sformatf("v%0d.frz_run_cnt", i), f_run_cnt, e.rc);
        end

        // Start before calibration: wait in PEND, run once calibration arrives.
        tick(); calib = 1'b0; cpu_start = 1'b1;
        @(negedge clk); chk("pend.t0_state", run_state, 3'd0);
        for (int k = 1; k <= 10; k++) begin
            tick(); calib = (k == 10);
            @(negedge clk);
            chk($sformatf("pend.t%0d_state", k), run_state, 3'd1);
            chk($sformatf("pend.t%0d_pc", k), pc_start, 1'b0);
        end
        tick();
        @(negedge clk); chk("pend.run_state", run_state, 3'd2); chk("pend.run_pc", pc_start, 1'b1);
        tick(); quit_cmd = 1'b1;
        @(negedge clk); chk("pend.pc_once", pc_start, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk); chk($sformatf("pend.drain%0d", k), run_state, 3'd4);
        end
        tick();
        @(negedge clk); chk("pend.idle", run_state, 3'd0);

        // step_num of zero executes a single slot.
        tick(); step_cmd = 1'b1; step_num = 16'd0;
        @(negedge clk);
        tick();
        @(negedge clk); chk("step0.state", run_state, 3'd3); chk("step0.done", step_done, 1'b1);
        tick();
        @(negedge clk); chk("step0.drain", run_state, 3'd4); chk("step0.done_once", step_done, 1'b0);
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk); chk("step0.idle", run_state, 3'd0);

        // Asynchronous reset in the middle of a long step.
        tick(); step_cmd = 1'b1; step_num = 16'd10;
        @(negedge clk);
        tick();
        @(negedge clk); chk("rstmid.step", run_state, 3'd3);
        tick();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.state",     run_state,   3'd0);
        chk("rstmid.pc_start",  pc_start,    1'b0);
        chk("rstmid.stall",     stall,       1'b1);
        chk("rstmid.stall_stg", stall_stg,   5'b11111);
        chk("rstmid.1shot",     stall_1shot, 1'b0);
        chk("rstmid.rst_pipe",  rst_pipe,    5'b00000);
        chk("rstmid.step_done", step_done,   1'b0);
        chk("rstmid.run_cnt",   run_cnt,     32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("post.c%0d", k), {run_state, pc_start, rst_pipe, step_done}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
